imem_stream_loader: RTL and testbench

- Hardware writer for the CPU instruction memory; counterpart to the instruction fetch path that only reads it.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake.
- Optionally zero-fills the memory first, then writes the words from address 0 upward.
- Holds the CPU in reset while loading; afterwards sequences CPU reset release and start, so the CPU runs without testbench back-door loading.

---
 rtl/imem_stream_loader.sv | 142 ++++++++++++++
 tb/tb_imem_stream_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - streams a program into instruction memory, then releases and starts the CPU.
// Define IMEM_CLEAR_EN to zero-fill the whole memory before each load session.
module imem_stream_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_req_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_data_o,
    output logic              cpu_rst_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t            state_q;
    logic              s_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              cpu_rst_q;
    logic              cpu_start_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              start_req;
    logic              beat_acc;

    assign start_req = load_req_i && (state_q == S_IDLE || state_q == S_RUN);
    assign beat_acc  = s_valid_i && s_ready_q && (state_q == S_LOAD);
    assign cnt_d     = cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            s_ready_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_rst_q   <= 1'b1;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (start_req) begin
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            cpu_rst_q   <= 1'b1;
            cpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef IMEM_CLEAR_EN
            state_q     <= S_CLEAR;
            we_q        <= 1'b1;
            s_ready_q   <= 1'b0;
`else
            state_q     <= S_LOAD;
            we_q        <= 1'b0;
            s_ready_q   <= 1'b1;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q   <= S_LOAD;
                        s_ready_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        we_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // ready drops after the last beat; this cycle carries its write
                    if (!s_ready_q) begin
                        state_q   <= S_RELEASE;
                        cpu_rst_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (beat_acc) begin
                        if (cnt_q < DEPTH_C) begin
                            we_q   <= 1'b1;
                            addr_q <= cnt_q[ADDR_W-1:0];
                            data_q <= s_data_i;
                            cnt_q  <= cnt_d;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        if (s_last_i) begin
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                S_RELEASE: begin
                    state_q     <= S_RUN;
                    cpu_start_q <= 1'b1;
                    done_q      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign s_ready_o    = s_ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign cpu_start_o  = cpu_start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign word_count_o = cnt_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - self-checking bench for imem_stream_loader (either IMEM_CLEAR_EN build).
module tb_imem_stream_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
`ifdef IMEM_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              load_req_i = 1'b0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [DATA_W-1:0] s_data_i = '0;
    logic              s_last_i = 1'b0;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_o;
    logic              cpu_rst_o;
    logic              cpu_start_o;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;
    logic [ADDR_W:0]   word_count_o;

    imem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_req_i(load_req_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .cpu_rst_o(cpu_rst_o), .cpu_start_o(cpu_start_o), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o), .word_count_o(word_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // the instruction memory the loader writes, plus a log of every write
    logic [DATA_W-1:0] dut_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    int                wl_a [$];
    int                wl_c [$];
    logic [DATA_W-1:0] wl_d [$];

    always @(negedge clk_i) begin
        if (imem_we_o === 1'b1) begin
            dut_mem[imem_addr_o] = imem_data_o;
            wl_a.push_back(int'(imem_addr_o));
            wl_d.push_back(imem_data_o);
            wl_c.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int             n;
        int             mode;      // 0 back-to-back, 1 valid pattern 1,0,0,1,1, 2 random
        int             abort_at;  // >0: reset after this many accepted beats
        logic [ADDR_W:0] exp_cnt;
        logic           exp_ovf;
    } vec_t;

    task automatic session(input int n, input int mode, input int abort_at,
                           input logic [ADDR_W:0] exp_cnt, input logic exp_ovf);
        logic [DATA_W-1:0] w [$];
        logic [DATA_W-1:0] plan [3];
        int                acc_c [$];
        logic [4:0]        pat;
        int                idx, p, req_cyc, budget, bad, nd, base;
        bit                acc, acc_prev, first, v;
        plan[0] = 32'h00500093;
        plan[1] = 32'h00108133;
        plan[2] = 32'h002081B3;
        pat = 5'b11001;
        for (int i = 0; i < n; i++) w.push_back(n == 3 ? plan[i] : $urandom);
        wl_a.delete(); wl_d.delete(); wl_c.delete();
        if (CLEAR_EN) for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        @(negedge clk_i);
        load_req_i = 1'b1;
        req_cyc = cyc + 1;
        idx = 0; p = 0; acc = 0; first = 1; budget = DEPTH + 8 * n + 64;
        forever begin
            @(negedge clk_i);
            acc_prev = acc;
            if (first) begin
                chk("session_start_flags", {busy_o, cpu_rst_o, cpu_start_o, done_o, overflow_o, s_ready_o},
                    {5'b11000, !CLEAR_EN});
                chk("session_start_count", word_count_o, 0);
                first = 0;
            end
            if (acc_prev && idx == DEPTH) begin
                chk("full_no_overflow", {overflow_o, word_count_o}, {1'b0, 9'(DEPTH)});
            end
            if (acc_prev && idx == DEPTH + 1) begin
                chk("overflow_after_extra_beat", {overflow_o, word_count_o}, {1'b1, 9'(DEPTH)});
            end
            if (idx == n || (abort_at > 0 && idx == abort_at) || budget == 0) break;
            budget--;
            load_req_i = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (s_ready_o) begin
                v = (mode == 0) ? 1'b1 : (mode == 1) ? pat[p % 5] : 1'($urandom_range(0, 1));
                p++;
            end else begin
                v = 1'($urandom_range(0, 1));
            end
            s_valid_i = v;
            s_data_i  = w[idx];
            s_last_i  = (idx == n - 1);
            acc = v && s_ready_o;
            if (acc) begin
                acc_c.push_back(cyc + 1);
                if (idx < DEPTH) exp_mem[idx] = w[idx];
                idx++;
            end
        end
        s_valid_i = 1'b0; load_req_i = 1'b0; s_last_i = 1'b0;
        if (budget == 0) begin
            chk("load_progress_timeout", idx, n);
            return;
        end
        if (abort_at > 0 && idx == abort_at) begin
            @(posedge clk_i);
            #2 rst_n_i = 1'b0;
            #1;
            chk("abort_reset_flags", {cpu_rst_o, cpu_start_o, s_ready_o, busy_o, done_o, imem_we_o, overflow_o},
                7'b1000000);
            chk("abort_reset_count", word_count_o, exp_cnt);
            @(negedge clk_i);
            rst_n_i = 1'b1;
            for (int k = 0; k < 3; k++) begin
                s_valid_i = 1'b1;
                @(negedge clk_i);
                chk("idle_after_reset", {cpu_rst_o, s_ready_o, busy_o, imem_we_o}, 4'b1000);
            end
            s_valid_i = 1'b0;
        end else begin
            chk("last_write_cycle", {imem_we_o, cpu_rst_o, s_ready_o}, {(n <= DEPTH), 2'b10});
            @(negedge clk_i);
            chk("release_cycle", {cpu_rst_o, cpu_start_o, imem_we_o, done_o}, 4'b0000);
            @(negedge clk_i);
            chk("run_flags", {cpu_rst_o, cpu_start_o, done_o, busy_o}, 4'b0110);
            chk("run_count", {overflow_o, word_count_o}, {exp_ovf, exp_cnt});
        end
        if (mode == 0 && idx > 0) begin
            chk("first_data_latency", acc_c[0] - req_cyc, CLEAR_EN ? DEPTH + 1 : 1);
        end
        nd = (idx > DEPTH) ? DEPTH : idx;
        base = CLEAR_EN ? DEPTH : 0;
        chk("write_log_size", wl_a.size(), base + nd);
        bad = 0;
        for (int e = 0; e < wl_a.size() && e < base + nd; e++) begin
            if (e < base) begin
                if (wl_a[e] != e || wl_d[e] !== '0 || wl_c[e] != req_cyc + e) bad++;
            end else begin
                if (wl_a[e] != e - base || wl_d[e] !== w[e - base] || wl_c[e] != acc_c[e - base]) bad++;
            end
        end
        chk("write_log_entries_bad", bad, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== exp_mem[i]) bad++;
        chk("memory_image_bad_words", bad, 0);
    endtask

    vec_t vecs [9];
    int   rn;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = 32'hDEADBEEF;
            exp_mem[i] = 32'hDEADBEEF;
        end
        vecs[0] = '{n: 3,   mode: 0, abort_at: 0, exp_cnt: 3,   exp_ovf: 0};
        vecs[1] = '{n: 3,   mode: 1, abort_at: 0, exp_cnt: 3,   exp_ovf: 0};
        vecs[2] = '{n: 2,   mode: 0, abort_at: 0, exp_cnt: 2,   exp_ovf: 0};
        vecs[3] = '{n: 258, mode: 0, abort_at: 0, exp_cnt: 256, exp_ovf: 1};
        vecs[4] = '{n: 10,  mode: 0, abort_at: 5, exp_cnt: 0,   exp_ovf: 0};
        vecs[5] = '{n: 1,   mode: 0, abort_at: 0, exp_cnt: 1,   exp_ovf: 0};
        vecs[6] = '{n: 256, mode: 2, abort_at: 0, exp_cnt: 256, exp_ovf: 0};
        vecs[7] = '{n: 257, mode: 1, abort_at: 0, exp_cnt: 256, exp_ovf: 1};
        vecs[8] = '{n: 5,   mode: 2, abort_at: 0, exp_cnt: 5,   exp_ovf: 0};

        #12;
        chk("reset_flags", {cpu_rst_o, cpu_start_o, s_ready_o, busy_o, done_o, imem_we_o, overflow_o}, 7'b1000000);
        chk("reset_count_addr", {word_count_o, imem_addr_o}, '0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_holds", {cpu_rst_o, s_ready_o, busy_o}, 3'b100);

        for (int t = 0; t < 9; t++) begin
            session(vecs[t].n, vecs[t].mode, vecs[t].abort_at, vecs[t].exp_cnt, vecs[t].exp_ovf);
            if (t == 2) chk("old_addr2_after_reload", dut_mem[2], CLEAR_EN ? 32'h0 : 32'h002081B3);
        end
        for (int r = 0; r < 4; r++) begin
            rn = $urandom_range(1, 40);
            session(rn, 2, 0, 9'(rn), 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
